data_break_ctl: RTL and testbench

DATA_BREAK_CTL -- requirements
Module: data_break_ctl

---
 rtl/data_break_ctl_pkg.sv | 28 ++
 rtl/data_break_ctl.sv | 132 +++++++++++++
 tb/tb_data_break_ctl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_break_ctl_pkg.sv
// Shared CPU break-state codes and the latched break request payload.
package data_break_ctl_pkg;

  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned STATE_W = 5;

  // State codes the disk controller compares against.
  localparam logic [STATE_W-1:0] IDLE_CODE = 5'd0;
  localparam logic [STATE_W-1:0] DB0       = 5'd16;
  localparam logic [STATE_W-1:0] DB1       = 5'd17;
  localparam logic [STATE_W-1:0] DB2       = 5'd18;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = IDLE_CODE,
    S_DB0  = DB0,
    S_DB1  = DB1,
    S_DB2  = DB2
  } brk_state_e;

  // Break request captured on DB0 entry.
  typedef struct packed {
    logic              to_disk;
    logic [0:ADDR_W-1] addr;
    logic [0:DATA_W-1] data;
  } brk_req_t;

endpackage

// File: rtl/data_break_ctl.sv
// Data-break controller: steals memory cycles for the disk, with forced CPU turns.
module data_break_ctl
  import data_break_ctl_pkg::*;
#(
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_break,
  input  logic              to_disk,
  input  logic [0:14]       dmaAddr,
  input  logic [0:11]       dmaDOUT,
  output logic [0:11]       dmaDIN,
  input  logic              cpu_boundary,
  output logic              break_in_prog,
  output logic [4:0]        state,
  output logic [0:14]       mem_addr,
  output logic [0:11]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [0:11]       mem_rdata,
  output logic [0:11]       break_count
);

  localparam int unsigned CONS_W = $clog2(MAX_CONSEC + 1);

  brk_state_e        state_q, state_d;
  brk_req_t          req_q, req_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic              bip_q, bip_d;
  logic [0:DATA_W-1] din_q, din_d;
  logic [0:DATA_W-1] count_q, count_d;
  logic [CONS_W-1:0] consec_q, consec_d;
  logic              forced_q, forced_d;
  logic              enter_db0;

  // Next-state, request latch, strobes, counters and forced-turn flag.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    mem_re_d  = 1'b0;
    mem_we_d  = 1'b0;
    din_d     = din_q;
    count_d   = count_q;
    consec_d  = consec_q;
    forced_d  = forced_q;
    enter_db0 = 1'b0;

    case (state_q)
      S_IDLE: begin
        consec_d = '0;
        // One cycle away from a CPU boundary gives the CPU its turn.
        if (forced_q && !cpu_boundary) begin
          forced_d = 1'b0;
        end
        if (data_break && cpu_boundary && !forced_q) begin
          enter_db0 = 1'b1;
        end
      end
      S_DB0: begin
        state_d = S_DB1;
      end
      S_DB1: begin
        state_d = S_DB2;
        if (req_q.to_disk) begin
          din_d = mem_rdata;
        end
      end
      S_DB2: begin
        count_d = count_q + DATA_W'(1);
        if (consec_q >= CONS_W'(MAX_CONSEC)) begin
          forced_d = 1'b1;
          state_d  = S_IDLE;
        end else if (data_break) begin
          enter_db0 = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Common DB0 entry: capture the request and fire the single memory strobe.
    if (enter_db0) begin
      state_d  = S_DB0;
      consec_d = consec_d + CONS_W'(1);
      req_d    = '{to_disk: to_disk, addr: dmaAddr, data: dmaDOUT};
      mem_re_d = to_disk;
      mem_we_d = !to_disk;
    end

    bip_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      bip_q    <= 1'b0;
      din_q    <= '0;
      count_q  <= '0;
      consec_q <= '0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      mem_re_q <= mem_re_d;
      mem_we_q <= mem_we_d;
      bip_q    <= bip_d;
      din_q    <= din_d;
      count_q  <= count_d;
      consec_q <= consec_d;
      forced_q <= forced_d;
    end
  end

  assign state         = state_q;
  assign break_in_prog = bip_q;
  assign mem_re        = mem_re_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = req_q.addr;
  assign mem_wdata     = req_q.data;
  assign dmaDIN        = din_q;
  assign break_count   = count_q;

endmodule

// File: tb/tb_data_break_ctl.sv
// Bench for data_break_ctl: directed table, corner sequences and random traffic vs. a break-level model.
module tb_data_break_ctl;
  import data_break_ctl_pkg::*;

  localparam int unsigned MAXC = 4;

  logic        clk = 1'b0;
  logic        reset, data_break, to_disk, cpu_boundary;
  logic [0:14] dmaAddr, mem_addr;
  logic [0:11] dmaDOUT, dmaDIN, mem_wdata, mem_rdata, break_count;
  logic        mem_we, mem_re, break_in_prog;
  logic [4:0]  state;

  always #5 clk = ~clk;

  data_break_ctl #(.MAX_CONSEC(MAXC)) dut (
    .clk(clk), .reset(reset), .data_break(data_break), .to_disk(to_disk),
    .dmaAddr(dmaAddr), .dmaDOUT(dmaDOUT), .dmaDIN(dmaDIN),
    .cpu_boundary(cpu_boundary), .break_in_prog(break_in_prog), .state(state),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .break_count(break_count)
  );

  // Memory with one-clock read latency.
  logic [0:11] ram [0:32767];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Break-level reference model: phase 0 = idle, 1..3 = cycles of a break.
  logic [0:11] mdl_mem [0:32767];
  int          m_phase, m_run, m_count;
  bit          m_forced, m_dir;
  logic [0:14] m_addr;
  logic [0:11] m_data, m_din;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [4:0] code_of(int p);
    case (p)
      1:       return DB0;
      2:       return DB1;
      3:       return DB2;
      default: return IDLE_CODE;
    endcase
  endfunction

  task automatic mdl_begin();
    m_phase = 1;
    m_run   = m_run + 1;
    m_addr  = dmaAddr;
    m_dir   = to_disk;
    m_data  = dmaDOUT;
    if (!to_disk) mdl_mem[dmaAddr] = dmaDOUT;
  endtask

  task automatic mdl_step();
    if (reset) begin
      m_phase = 0; m_run = 0; m_forced = 0; m_count = 0; m_din = '0;
    end else begin
      case (m_phase)
        0: begin
          m_run = 0;
          if (m_forced && !cpu_boundary) m_forced = 0;
          else if (data_break && cpu_boundary && !m_forced) mdl_begin();
        end
        1: m_phase = 2;
        2: begin
          if (m_dir) m_din = mdl_mem[m_addr];
          m_phase = 3;
        end
        default: begin
          m_count = (m_count + 1) % 4096;
          if (m_run >= int'(MAXC)) begin
            m_forced = 1; m_phase = 0;
          end else if (data_break) begin
            mdl_begin();
          end else begin
            m_phase = 0;
          end
        end
      endcase
    end
  endtask

  task automatic check_model(string tag);
    logic [4:0]  e_state;
    logic        e_bip, e_re, e_we;
    bit          bad;
    e_state = code_of(m_phase);
    e_bip   = (m_phase != 0);
    e_re    = (m_phase == 1) && m_dir;
    e_we    = (m_phase == 1) && !m_dir;
    bad = (state !== e_state) || (break_in_prog !== e_bip) || (mem_re !== e_re) ||
          (mem_we !== e_we) || (dmaDIN !== m_din) || (break_count !== 12'(m_count)) ||
          ((m_phase == 1) && (mem_addr !== m_addr)) || (e_we && (mem_wdata !== m_data));
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL model/%s t=%0t state=%0o/%0o bip=%b/%b re=%b/%b we=%b/%b din=%0o/%0o cnt=%0o/%0o addr=%0o/%0o wdata=%0o/%0o (got/want)",
               tag, $time, state, e_state, break_in_prog, e_bip, mem_re, e_re, mem_we, e_we,
               dmaDIN, m_din, break_count, 12'(m_count), mem_addr, m_addr, mem_wdata, m_data);
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o want %0o", name, act, exp);
    end
  endtask

  task automatic drive(bit r, bit db, bit cb, bit td, logic [0:14] a, logic [0:11] d);
    reset = r; data_break = db; cpu_boundary = cb; to_disk = td; dmaAddr = a; dmaDOUT = d;
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    mdl_step();
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit          rst, db, cb, td;
    logic [0:14] addr;
    logic [0:11] dout;
    logic [4:0]  e_state;
    bit          e_bip, e_re, e_we;
    logic [0:11] e_din, e_cnt;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int n_db0;
    int guard;
    bit cb_r;
    logic [0:11] rv;

    drive(1, 0, 1, 1, '0, '0);
    for (int i = 0; i < 32768; i++) begin
      rv = 12'($urandom);
      ram[i] = rv;
      mdl_mem[i] = rv;
    end
    ram[15'o12345] = 12'o4321;
    mdl_mem[15'o12345] = 12'o4321;

    // Reset, deferred request for 10 cycles, then a read break.
    tbl[0] = '{1, 0, 1, 1, 15'o0, 12'o0, IDLE_CODE, 0, 0, 0, 12'o0, 12'o0};
    for (int i = 1; i <= 10; i++)
      tbl[i] = '{0, 1, 0, 1, 15'o12345, 12'o1111, IDLE_CODE, 0, 0, 0, 12'o0, 12'o0};
    tbl[11] = '{0, 1, 1, 1, 15'o12345, 12'o1111, DB0, 1, 1, 0, 12'o0, 12'o0};
    tbl[12] = '{0, 0, 1, 0, 15'o77777, 12'o5555, DB1, 1, 0, 0, 12'o0, 12'o0};
    tbl[13] = '{0, 0, 1, 0, 15'o77777, 12'o5555, DB2, 1, 0, 0, 12'o4321, 12'o0};
    tbl[14] = '{0, 0, 1, 0, 15'o77777, 12'o5555, IDLE_CODE, 0, 0, 0, 12'o4321, 12'o1};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].db, tbl[i].cb, tbl[i].td, tbl[i].addr, tbl[i].dout);
      tick("tbl");
      n_vec++;
      if (state !== tbl[i].e_state || break_in_prog !== tbl[i].e_bip || mem_re !== tbl[i].e_re ||
          mem_we !== tbl[i].e_we || dmaDIN !== tbl[i].e_din || break_count !== tbl[i].e_cnt ||
          (tbl[i].e_re && mem_addr !== 15'o12345)) begin
        n_err++;
        $display("FAIL tbl[%0d]: state=%0o/%0o bip=%b/%b re=%b/%b we=%b/%b din=%0o/%0o cnt=%0o/%0o addr=%0o (got/want)",
                 i, state, tbl[i].e_state, break_in_prog, tbl[i].e_bip, mem_re, tbl[i].e_re,
                 mem_we, tbl[i].e_we, dmaDIN, tbl[i].e_din, break_count, tbl[i].e_cnt, mem_addr);
      end
    end

    // Write break.
    drive(0, 1, 1, 0, 15'o00200, 12'o7070);
    tick("wr");
    chk("wr_we", 32'(mem_we), 32'd1);
    chk("wr_wdata", 32'(mem_wdata), 32'o7070);
    drive(0, 0, 1, 0, 15'o00000, 12'o0000);
    for (int i = 0; i < 3; i++) tick("wr");
    chk("wr_ram", 32'(ram[15'o00200]), 32'o7070);

    // Fairness: request held, CPU always at a boundary.
    n_db0 = 0;
    drive(0, 1, 1, 1, 15'o00100, 12'o0);
    for (int i = 0; i < 20; i++) begin
      dmaAddr = 15'($urandom);
      tick("fair");
      if (state == DB0) n_db0++;
    end
    chk("fair_burst", 32'(n_db0), 32'd4);
    chk("fair_blocked", 32'(state), 32'(IDLE_CODE));
    cpu_boundary = 0;
    tick("fair");
    cpu_boundary = 1;
    tick("fair");
    chk("fair_resume", 32'(state), 32'(DB0));
    for (int i = 0; i < 5; i++) tick("fair");
    data_break = 0;
    for (int i = 0; i < 4; i++) tick("fair");

    // Reset mid-break in DB1.
    drive(0, 1, 1, 1, 15'o01234, 12'o0);
    tick("rst");
    data_break = 0;
    tick("rst");
    chk("rst_db1", 32'(state), 32'(DB1));
    reset = 1;
    tick("rst");
    chk("rst_state", 32'(state), 32'(IDLE_CODE));
    chk("rst_bip", 32'(break_in_prog), 32'd0);
    chk("rst_strobes", 32'({mem_we, mem_re}), 32'd0);
    reset = 0;
    tick("rst");
    chk("rst_after", 32'({mem_we, mem_re, break_in_prog}), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            1'($urandom), 15'($urandom), 12'($urandom));
      tick("rand");
    end

    // Counter wrap: 4095 breaks, then one more.
    drive(1, 0, 1, 1, '0, '0);
    tick("wrap");
    guard = 0;
    while (m_count < 4095 && guard < 20000) begin
      cb_r = !(m_phase == 0 && m_forced);
      drive(0, (m_count + ((m_phase != 0) ? 1 : 0)) < 4095, cb_r, 1'($urandom),
            15'($urandom), 12'($urandom));
      tick("wrap");
      guard++;
    end
    chk("wrap_budget", 32'(guard < 20000), 32'd1);
    drive(0, 0, 1, 1, '0, '0);
    tick("wrap");
    chk("cnt_7777", 32'(break_count), 32'o7777);
    cpu_boundary = 0;
    tick("wrap");
    drive(0, 1, 1, 1, 15'o00010, 12'o0);
    tick("wrap");
    data_break = 0;
    for (int i = 0; i < 3; i++) tick("wrap");
    chk("cnt_wrap", 32'(break_count), 32'o0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
